// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 round controller.
package aes_ctrl_pkg;

    typedef logic [15:0][7:0] aes_block_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } ctrl_state_t;

    localparam logic [1:0] STG_SUB   = 2'd0;
    localparam logic [1:0] STG_SHIFT = 2'd1;
    localparam logic [1:0] STG_MIX   = 2'd2;
    localparam logic [1:0] STG_ARK   = 2'd3;

    localparam int DEFAULT_NUM_ROUNDS    = 10;
    localparam int DEFAULT_STAGE_TIMEOUT = 255;

    // Stage index to the one-hot start vector seen by the datapath stages.
    function automatic logic [3:0] stage_onehot(input logic [1:0] stg);
        return 4'b0001 << stg;
    endfunction

endpackage

// File: rtl/aes_stage_timer.sv
// Stage watchdog: counts cycles since the last clear and flags when TIMEOUT is reached.
module aes_stage_timer #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [7:0] r_count;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = (r_count == TIMEOUT);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer driving shared byte_sub/shift_rows/mix_columns/add_round_key stages.
// Define AES_ROUND_CTRL_PENDING_EN to buffer one block that arrives while a run is in progress.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS    = DEFAULT_NUM_ROUNDS,
    parameter int STAGE_TIMEOUT = DEFAULT_STAGE_TIMEOUT
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             block_valid_in,
    input  logic [15:0][7:0] block_in,
    output logic             ready_out,
    output logic [3:0]       stage_start_out,
    output logic [15:0][7:0] state_out,
    output logic [3:0]       round_out,
    input  logic             stage_done_in,
    input  logic [15:0][7:0] stage_result_in,
    output logic [15:0][7:0] result_out,
    output logic             valid_out,
    output logic             busy_out,
    output logic             error_out
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [7:0] TIMEOUT    = 8'(STAGE_TIMEOUT);

    ctrl_state_t r_fsm, w_fsm_next;
    aes_block_t  r_state, w_state_next;
    aes_block_t  r_result, w_result_next;
    logic [3:0]  r_round, w_round_next;
    logic [1:0]  r_stage, w_stage_next;
    logic        w_launch;
    logic        w_drain;
    logic        w_next_valid;
    aes_block_t  w_next_block;
    logic        w_timer_expired;

`ifdef AES_ROUND_CTRL_PENDING_EN
    logic       r_pend_valid;
    aes_block_t r_pend_block;

    // A buffered block takes priority; otherwise a block arriving in DONE/ERR is used directly.
    assign w_next_valid = r_pend_valid | block_valid_in;
    assign w_next_block = r_pend_valid ? r_pend_block : block_in;
    assign w_drain      = (r_fsm == ST_DONE) || (r_fsm == ST_ERR);
    assign ready_out    = (r_fsm == ST_IDLE) || !r_pend_valid;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_pend_valid <= 1'b0;
            r_pend_block <= '0;
        end else if (w_drain && r_pend_valid) begin
            r_pend_valid <= 1'b0;
        end else if ((r_fsm == ST_ISSUE || r_fsm == ST_WAIT) && block_valid_in && !r_pend_valid) begin
            r_pend_valid <= 1'b1;
            r_pend_block <= block_in;
        end
    end
`else
    assign w_next_valid = block_valid_in;
    assign w_next_block = block_in;
    assign w_drain      = 1'b0;
    assign ready_out    = (r_fsm == ST_IDLE);
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        w_fsm_next    = r_fsm;
        w_state_next  = r_state;
        w_result_next = r_result;
        w_round_next  = r_round;
        w_stage_next  = r_stage;
        w_launch      = 1'b0;

        case (r_fsm)
            ST_IDLE:  w_launch = w_next_valid;
            ST_ISSUE: w_fsm_next = ST_WAIT;
            ST_WAIT: begin
                if (stage_done_in) begin
                    w_state_next = stage_result_in;
                    w_fsm_next   = ST_ISSUE;
                    case (r_stage)
                        STG_SUB:   w_stage_next = STG_SHIFT;
                        STG_SHIFT: w_stage_next = (r_round == LAST_ROUND) ? STG_ARK : STG_MIX;
                        STG_MIX:   w_stage_next = STG_ARK;
                        default: begin
                            if (r_round == LAST_ROUND) begin
                                w_fsm_next    = ST_DONE;
                                w_result_next = stage_result_in;
                            end else begin
                                w_round_next = r_round + 4'd1;
                                w_stage_next = STG_SUB;
                            end
                        end
                    endcase
                end else if (w_timer_expired) begin
                    w_fsm_next = ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                w_fsm_next = ST_IDLE;
                w_launch   = w_drain && w_next_valid;
            end
            default: w_fsm_next = ST_IDLE;
        endcase

        if (w_launch) begin
            w_fsm_next   = ST_ISSUE;
            w_state_next = w_next_block;
            w_round_next = '0;
            w_stage_next = STG_ARK;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_fsm    <= ST_IDLE;
            r_state  <= '0;
            r_result <= '0;
            r_round  <= '0;
            r_stage  <= STG_SUB;
        end else begin
            r_fsm    <= w_fsm_next;
            r_state  <= w_state_next;
            r_result <= w_result_next;
            r_round  <= w_round_next;
            r_stage  <= w_stage_next;
        end
    end

    // Cleared on every entry to ISSUE, so the count equals cycles since the stage start.
    aes_stage_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .i_clear   (w_fsm_next == ST_ISSUE),
        .i_enable  ((r_fsm == ST_ISSUE) || (r_fsm == ST_WAIT)),
        .o_expired (w_timer_expired)
    );

    assign stage_start_out = (r_fsm == ST_ISSUE) ? stage_onehot(r_stage) : 4'b0000;
    assign state_out       = r_state;
    assign round_out       = r_round;
    assign result_out      = r_result;
    assign valid_out       = (r_fsm == ST_DONE);
    assign error_out       = (r_fsm == ST_ERR);
    assign busy_out        = (r_fsm != ST_IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl with responding stage stubs and a sequence-level model.
module tb_aes_round_ctrl;
    import aes_ctrl_pkg::*;

    localparam int NR = 10;
    localparam int S_SUB = 0, S_SHIFT = 1, S_MIX = 2, S_ARK = 3;

    typedef struct {
        int stg;
        int rnd;
    } start_t;

    logic             clk_in;
    logic             rst_in;
    logic             block_valid_in;
    logic [15:0][7:0] block_in;
    logic             ready_out;
    logic [3:0]       stage_start_out;
    logic [15:0][7:0] state_out;
    logic [3:0]       round_out;
    logic             stage_done_in;
    logic [15:0][7:0] stage_result_in;
    logic [15:0][7:0] result_out;
    logic             valid_out;
    logic             busy_out;
    logic             error_out;

    aes_round_ctrl #(.NUM_ROUNDS(NR), .STAGE_TIMEOUT(255)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .block_valid_in  (block_valid_in),
        .block_in        (block_in),
        .ready_out       (ready_out),
        .stage_start_out (stage_start_out),
        .state_out       (state_out),
        .round_out       (round_out),
        .stage_done_in   (stage_done_in),
        .stage_result_in (stage_result_in),
        .result_out      (result_out),
        .valid_out       (valid_out),
        .busy_out        (busy_out),
        .error_out       (error_out)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int c0      = 0;

    int stub_delay = 1;
    int mute_en    = 0;
    int mute_round = 3;
    int mute_cyc   = -1;
    int early_en   = 0;
    int stray_en   = 0;

    int         vq[$];
    aes_block_t rq[$];
    int         eq[$];
    start_t     starts_q[$];
    start_t     exp_q[$];

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stand-in datapath stages, deliberately simple but distinct and order-sensitive.
    function automatic aes_block_t stub_apply(input int stg, input aes_block_t s);
        aes_block_t r;
        r = s;
        case (stg)
            S_SUB:   for (int i = 0; i < 16; i++) r[i] = s[i] + 8'h5b;
            S_SHIFT: r = {s[14:0], s[15]};
            S_MIX:   r = {s[7:0], s[15:8]} ^ {16{8'ha5}};
            default: r = s ^ 128'h01;
        endcase
        return r;
    endfunction

    // Reference: round 0 is a key add; rounds 1..NR-1 are full; the last round has no mix.
    task automatic model_run(input aes_block_t pt, output aes_block_t ct);
        aes_block_t s;
        start_t     e;
        exp_q.delete();
        s = pt;
        e.stg = S_ARK; e.rnd = 0; exp_q.push_back(e);
        s = stub_apply(S_ARK, s);
        for (int r = 1; r <= NR; r++) begin
            for (int k = 0; k < 4; k++) begin
                if (k == S_MIX && r == NR) continue;
                e.stg = k; e.rnd = r; exp_q.push_back(e);
                s = stub_apply(k, s);
            end
        end
        ct = s;
    endtask

    function automatic int seq_mismatches();
        int m;
        m = (starts_q.size() > exp_q.size()) ? starts_q.size() - exp_q.size()
                                             : exp_q.size() - starts_q.size();
        for (int i = 0; i < starts_q.size() && i < exp_q.size(); i++)
            if (starts_q[i].stg != exp_q[i].stg || starts_q[i].rnd != exp_q[i].rnd) m++;
        return m;
    endfunction

    function automatic int count_stage(input int stg);
        int n;
        n = 0;
        foreach (starts_q[i]) if (starts_q[i].stg == stg) n++;
        return n;
    endfunction

    function automatic aes_block_t rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic clear_logs();
        vq.delete(); rq.delete(); eq.delete(); starts_q.delete();
        mute_cyc = -1;
    endtask

    task automatic send_block(input aes_block_t b);
        @(negedge clk_in);
        block_valid_in = 1'b1;
        block_in       = b;
        c0             = cyc;
        @(negedge clk_in);
        block_valid_in = 1'b0;
    endtask

    // Stage stubs and output monitor, all acting on the falling edge.
    initial begin
        int         cd;
        int         stg;
        aes_block_t pend_res;
        start_t     s;
        cd = 0;
        pend_res = '0;
        stage_done_in   = 1'b0;
        stage_result_in = '0;
        forever begin
            @(negedge clk_in);
            stage_done_in = 1'b0;
            if (!rst_in) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        stage_done_in   = 1'b1;
                        stage_result_in = pend_res;
                    end
                end
                if (stage_start_out != 4'b0000) begin
                    case (stage_start_out)
                        4'b0001: stg = S_SUB;
                        4'b0010: stg = S_SHIFT;
                        4'b0100: stg = S_MIX;
                        4'b1000: stg = S_ARK;
                        default: stg = -1;
                    endcase
                    s.stg = stg; s.rnd = int'(round_out);
                    starts_q.push_back(s);
                    if (mute_en != 0 && stg == S_MIX && int'(round_out) == mute_round) begin
                        mute_cyc = cyc;
                    end else if (stg >= 0) begin
                        cd       = stub_delay;
                        pend_res = stub_apply(stg, state_out);
                    end
                    if (early_en != 0) begin
                        stage_done_in   = 1'b1;
                        stage_result_in = ~state_out;
                    end
                end
                if (stray_en != 0) begin
                    stage_done_in   = 1'b1;
                    stage_result_in = rand_block();
                end
                if (valid_out) begin
                    vq.push_back(cyc);
                    rq.push_back(result_out);
                end
                if (error_out) eq.push_back(cyc);
            end
        end
    end

    task automatic test_reset();
        aes_block_t pt, ct;
        int lat;
        rst_in = 1'b0;
        block_valid_in = 1'b0;
        block_in = '0;
        repeat (3) @(negedge clk_in);
        n_tests++;
        if (ready_out !== 1'b1 || busy_out !== 1'b0 || valid_out !== 1'b0 || error_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: ready/busy/valid/error=%b%b%b%b expected 1000",
                     ready_out, busy_out, valid_out, error_out);
        end
        rst_in = 1'b1;

        // Reset mid-run, 30 cycles after the block was accepted.
        clear_logs();
        stub_delay = 1;
        pt = rand_block();
        send_block(pt);
        repeat (29) @(negedge clk_in);
        n_tests++;
        if (busy_out !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_busy: busy_out=%b expected 1", busy_out);
        end
        #1 rst_in = 1'b0;
        #1;
        n_tests++;
        if (ready_out !== 1'b1 || busy_out !== 1'b0 || valid_out !== 1'b0 || error_out !== 1'b0
            || stage_start_out !== 4'b0 || round_out !== 4'b0) begin
            n_fail++;
            $display("FAIL async_reset_ctrl: ready=%b busy=%b valid=%b err=%b start=%h round=%0d expected 1,0,0,0,0,0",
                     ready_out, busy_out, valid_out, error_out, stage_start_out, round_out);
        end
        n_tests++;
        if (state_out !== '0 || result_out !== '0) begin
            n_fail++;
            $display("FAIL async_reset_data: state=%h result=%h expected 0", state_out, result_out);
        end
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;

        clear_logs();
        pt = rand_block();
        model_run(pt, ct);
        send_block(pt);
        repeat (100) @(negedge clk_in);
        lat = (vq.size() > 0) ? vq[0] - c0 : -1;
        n_tests++;
        if (vq.size() != 1 || lat != 81 || rq[0] !== ct) begin
            n_fail++;
            $display("FAIL after_reset_run: pulses=%0d latency=%0d result=%h expected 1, 81, %h",
                     vq.size(), lat, (rq.size() > 0) ? rq[0] : '0, ct);
        end
    endtask

    task automatic test_single();
        aes_block_t pt, ct;
        int lat;
        stub_delay = 1;
        for (int t = 0; t < 3; t++) begin
            clear_logs();
            pt = rand_block();
            model_run(pt, ct);
            send_block(pt);
            repeat (100) @(negedge clk_in);
            lat = (vq.size() > 0) ? vq[0] - c0 : -1;
            n_tests++;
            if (vq.size() != 1 || lat != 81) begin
                n_fail++;
                $display("FAIL single_latency[%0d]: pulses=%0d latency=%0d expected 1 pulse at 81", t, vq.size(), lat);
            end
            n_tests++;
            if (rq.size() == 0 || rq[0] !== ct) begin
                n_fail++;
                $display("FAIL single_result[%0d]: got %h expected %h", t, (rq.size() > 0) ? rq[0] : '0, ct);
            end
            n_tests++;
            if (count_stage(S_SUB) != 10 || count_stage(S_SHIFT) != 10
                || count_stage(S_MIX) != 9 || count_stage(S_ARK) != 11) begin
                n_fail++;
                $display("FAIL single_counts[%0d]: sub=%0d shift=%0d mix=%0d ark=%0d expected 10,10,9,11", t,
                         count_stage(S_SUB), count_stage(S_SHIFT), count_stage(S_MIX), count_stage(S_ARK));
            end
            n_tests++;
            if (seq_mismatches() != 0) begin
                n_fail++;
                $display("FAIL single_sequence[%0d]: %0d stage/round mismatches expected 0", t, seq_mismatches());
            end
            n_tests++;
            if (busy_out !== 1'b0 || ready_out !== 1'b1 || result_out !== ct) begin
                n_fail++;
                $display("FAIL single_idle[%0d]: busy=%b ready=%b result=%h expected 0,1,%h",
                         t, busy_out, ready_out, result_out, ct);
            end
        end
    endtask

    task automatic test_slow();
        aes_block_t pt, ct;
        int lat;
        clear_logs();
        stub_delay = 5;
        early_en   = 1;
        pt = rand_block();
        model_run(pt, ct);
        send_block(pt);
        repeat (260) @(negedge clk_in);
        early_en   = 0;
        stub_delay = 1;
        lat = (vq.size() > 0) ? vq[0] - c0 : -1;
        n_tests++;
        if (vq.size() != 1 || lat != 241) begin
            n_fail++;
            $display("FAIL slow_latency: pulses=%0d latency=%0d expected 1 pulse at 241", vq.size(), lat);
        end
        n_tests++;
        if (rq.size() == 0 || rq[0] !== ct || seq_mismatches() != 0) begin
            n_fail++;
            $display("FAIL slow_result: got %h (seq mismatches %0d) expected %h (0)",
                     (rq.size() > 0) ? rq[0] : '0, seq_mismatches(), ct);
        end
    endtask

    task automatic test_timeout();
        aes_block_t pt, ct, prev;
        int dt;
        clear_logs();
        prev    = result_out;
        mute_en = 1;
        pt = rand_block();
        send_block(pt);
        repeat (400) @(negedge clk_in);
        mute_en = 0;
        dt = (eq.size() > 0 && mute_cyc >= 0) ? eq[0] - mute_cyc : -1;
        n_tests++;
        if (eq.size() != 1 || dt != 256) begin
            n_fail++;
            $display("FAIL timeout_error: pulses=%0d delay=%0d expected 1 pulse 256 after start", eq.size(), dt);
        end
        n_tests++;
        if (vq.size() != 0 || result_out !== prev || busy_out !== 1'b0 || ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_state: valids=%0d result=%h busy=%b ready=%b expected 0, %h, 0, 1",
                     vq.size(), result_out, busy_out, ready_out, prev);
        end

        clear_logs();
        pt = rand_block();
        model_run(pt, ct);
        send_block(pt);
        repeat (100) @(negedge clk_in);
        n_tests++;
        if (vq.size() != 1 || rq[0] !== ct || vq[0] - c0 != 81) begin
            n_fail++;
            $display("FAIL timeout_recover: pulses=%0d result=%h expected 1, %h",
                     vq.size(), (rq.size() > 0) ? rq[0] : '0, ct);
        end
    endtask

    task automatic test_back_to_back();
        aes_block_t a, b, ca, cb;
        for (int i = 0; i < 16; i++) begin
            a[i] = 8'h01 + 8'(i);
            b[i] = 8'h15 + 8'(i);
        end
        model_run(b, cb);
        model_run(a, ca);
        clear_logs();
        @(negedge clk_in);
        block_valid_in = 1'b1;
        block_in       = a;
        c0             = cyc;
        @(negedge clk_in);
        block_in       = b;
        @(negedge clk_in);
        block_valid_in = 1'b0;
        repeat (250) @(negedge clk_in);
        n_tests++;
        if (vq.size() < 1 || rq[0] !== ca || vq[0] - c0 != 81) begin
            n_fail++;
            $display("FAIL b2b_first: pulses=%0d result=%h expected %h at 81",
                     vq.size(), (rq.size() > 0) ? rq[0] : '0, ca);
        end
`ifdef AES_ROUND_CTRL_PENDING_EN
        n_tests++;
        if (vq.size() != 2 || rq[1] !== cb || vq[1] - vq[0] != 81) begin
            n_fail++;
            $display("FAIL b2b_pending: pulses=%0d second=%h expected 2 pulses 81 apart, %h",
                     vq.size(), (rq.size() > 1) ? rq[1] : '0, cb);
        end
`else
        n_tests++;
        if (vq.size() != 1) begin
            n_fail++;
            $display("FAIL b2b_drop: pulses=%0d expected 1", vq.size());
        end
`endif
    endtask

    task automatic test_stray();
        aes_block_t st, res;
        logic [3:0] rnd;
        clear_logs();
        st  = state_out;
        res = result_out;
        rnd = round_out;
        stray_en = 1;
        repeat (6) @(negedge clk_in);
        stray_en = 0;
        repeat (3) @(negedge clk_in);
        n_tests++;
        if (state_out !== st || result_out !== res || round_out !== rnd) begin
            n_fail++;
            $display("FAIL stray_state: state=%h result=%h round=%0d expected %h, %h, %0d",
                     state_out, result_out, round_out, st, res, rnd);
        end
        n_tests++;
        if (vq.size() != 0 || starts_q.size() != 0 || busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_activity: valids=%0d starts=%0d busy=%b expected 0, 0, 0",
                     vq.size(), starts_q.size(), busy_out);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_slow();
        test_timeout();
        test_back_to_back();
        test_stray();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequences one AES-128 encryption over the shared round datapath stages: byte_sub, shift_rows, mix_columns and add_round_key.
- Accepts a completed 128-bit block from create_block (its valid_out pulse) and issues one-hot stage starts in FIPS-197 order.
- Captures each stage's result and emits the ciphertext with a one-cycle valid pulse.
- Also supplies the round index to the key schedule.

Parameters:
- NUM_ROUNDS, 10, total AES rounds (final round omits mix_columns); legal range 2..15.
- STAGE_TIMEOUT, 255, max cycles to wait for stage_done_in before aborting; 8-bit counter.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- block_valid_in  input  1  one-cycle pulse, block_in valid (driven by create_block valid_out)
- block_in  input  [15:0][7:0]  plaintext block
- ready_out  output  1  controller can accept a block this cycle
- stage_start_out  output  4  one-hot start: bit0 byte_sub, bit1 shift_rows, bit2 mix_columns, bit3 add_round_key
- state_out  output  [15:0][7:0]  current state register, fed to all stages
- round_out  output  4  current round index for the key schedule
- stage_done_in  input  1  one-cycle pulse, active stage finished
- stage_result_in  input  [15:0][7:0]  active stage output, valid with stage_done_in
- result_out  output  [15:0][7:0]  ciphertext, held until next valid_out
- valid_out  output  1  one-cycle pulse, result_out updated
- busy_out  output  1  encryption in progress
- error_out  output  1  one-cycle pulse on stage timeout

Behaviour:
- Reset (rst_in low, takes effect immediately): FSM IDLE; all outputs 0 except ready_out=1; state, result, round and timer regs 0; pending slot empty.
- FSM states: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE: on block_valid_in, latch block_in into state, round=0, stage=ARK, go to ISSUE.
- ISSUE: assert the selected stage_start_out bit for exactly one cycle, clear timer, go to WAIT.
- WAIT: stage_done_in in the ISSUE cycle is ignored. On stage_done_in, load stage_result_in into state and advance:
  - round 0: ARK -> round 1 SUB.
  - rounds 1..NUM_ROUNDS-1: SUB -> SHIFT -> MIX -> ARK, then round+1.
  - round NUM_ROUNDS: SUB -> SHIFT -> ARK -> DONE.
  - Otherwise go to ISSUE.
- Timeout: timer reaches STAGE_TIMEOUT with no done -> ERR. ERR pulses error_out for one cycle, returns to IDLE, and leaves result_out unchanged.
- DONE: result_out <= state; valid_out=1 for one cycle; go to IDLE.
- Latency: with every stage answering one cycle after start, the run has 40 stages (1 + 9×4 + 3) and valid_out rises 81 cycles after the block_valid_in cycle.
- busy_out = FSM not IDLE. round_out holds its value from ISSUE through WAIT.
- ready_out = IDLE (base build).
- Stray stage_done_in in IDLE/DONE/ERR is ignored.
- block_valid_in while busy and not accepted is dropped; it has no effect on the current run.
- Simultaneous DONE and block_valid_in: the block is dropped in the base build.

Optional Feature:
- Macro AES_ROUND_CTRL_PENDING_EN.
- Defined: a one-entry pending buffer holds one block arriving while busy.
  - ready_out = IDLE or pending empty.
  - From DONE or ERR, the FSM goes directly to ISSUE with the pending block (round 0, ARK) on the next cycle, with no IDLE cycle.
  - A block arriving while pending is full is dropped.
  - Reset empties the buffer.
- Undefined: no buffer; behaviour as in Behaviour.

Decomposition:
- Package aes_ctrl_pkg:
  - typedef aes_block_t = logic [15:0][7:0].
  - FSM state enum.
  - Stage index localparams: STG_SUB=0, STG_SHIFT=1, STG_MIX=2, STG_ARK=3.
  - Default NUM_ROUNDS.
- One sub-module, aes_stage_timer: loadable 8-bit timeout counter with clear and expired flag.

Test Plan:
- Reset then idle: rst_in low mid-run at cycle 30 -> all outputs 0, ready_out=1 immediately; a new block after release runs fully.
- Single block, stub answers done 1 cycle after start (ARK stub returns state ^ 128'h01) -> start counts SUB=10, SHIFT=10, MIX=9, ARK=11; valid_out at cycle 81; result_out equals the final ARK stub output; round_out sequence 0,1..10.
- Stub waits 5 cycles per stage -> valid_out at cycle 1+40×6 = 241; done pulses in the ISSUE cycle are ignored.
- Timeout: mix_columns stub never answers in round 3 -> error_out pulse 256 cycles after that start; FSM back in IDLE; result_out unchanged; next block succeeds.
- Back-to-back blocks 8'h01.. / 8'h15.. from create_block: base build drops the second block (no second valid_out). With AES_ROUND_CTRL_PENDING_EN the second block starts the cycle after the first valid_out, giving two valid_out pulses 81 cycles apart.
- Stray stage_done_in while IDLE -> no state change, no valid_out.
